out_store: RTL and testbench

//  Reader/drain side of the GEMM output buffer. The GEMM core writes 128-bit result rows into
//  out_mem; this block reads a commanded range of rows back out and streams them downstream
//  (to the DRAM store path) over a valid/ready interface, one row per beat, with full backpressure.

---
 rtl/out_store.sv | 165 ++++++++++++++++
 tb/tb_out_store.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/out_store.sv
// Purpose: drains a commanded range of GEMM output-buffer rows onto a valid/ready stream, one row per beat.
// Latency: cmd handshake at cycle 0 -> rd_en at cycle 1 -> FIFO push at cycle 2 -> m_valid at cycle 3; N rows reach done at N+3.
// Backpressure: reads are only issued while FIFO entries plus in-flight reads minus this cycle's pop stay below FIFO_DEPTH.

module out_store_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] cnt
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_dat = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module out_store #(
  parameter int OUT_MEM_WIDTH = 128,
  parameter int BUF_ADR_WIDTH = 32,
  parameter int OUT_IDX_WIDTH = 12,
  parameter int CNT_WIDTH     = 16,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OUT_IDX_WIDTH-1:0] cmd_base_idx,
  input  logic [CNT_WIDTH-1:0]     cmd_count,
  output logic                     out_mem_rd_en,
  output logic [BUF_ADR_WIDTH-1:0] out_mem_rd_addr,
  input  logic [OUT_MEM_WIDTH-1:0] out_mem_rd_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUT_MEM_WIDTH-1:0] m_data,
  output logic                     m_last,
  output logic                     busy,
  output logic                     done
);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = OCC_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state;
  logic [OUT_IDX_WIDTH-1:0] cur_idx;
  logic [CNT_WIDTH-1:0]     row_cnt;
  logic [CNT_WIDTH-1:0]     issued;
  logic                     inflight;
  logic                     inflight_last;
  logic [OCC_W-1:0]         fifo_cnt;
  logic [OUT_MEM_WIDTH:0]   head;
  logic                     pop;
  logic                     room;
  logic                     last_rd;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Head entry carries its own last flag; gate it so m_last never shows while the stream is idle.
  assign m_valid = (fifo_cnt != '0);
  assign m_data  = head[OUT_MEM_WIDTH-1:0];
  assign m_last  = head[OUT_MEM_WIDTH] & m_valid;
  assign pop     = m_valid & m_ready;

  // Space check counts the pop in this same cycle so a full FIFO being drained keeps reads flowing.
  assign room    = (SUM_W'(fifo_cnt) + SUM_W'(inflight)) < (SUM_W'(FIFO_DEPTH) + SUM_W'(pop));
  assign last_rd = (issued == row_cnt - CNT_WIDTH'(1));

  assign out_mem_rd_en   = (state == RUN) && (issued != row_cnt) && room;
  assign out_mem_rd_addr = {{(BUF_ADR_WIDTH - OUT_IDX_WIDTH - 2){1'b0}}, cur_idx, 2'b00};

  // Command capture, read sequencing and completion; the row index wraps naturally at its width.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state   <= IDLE;
      cur_idx <= '0;
      row_cnt <= '0;
      issued  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_idx <= cmd_base_idx;
            row_cnt <= cmd_count;
            issued  <= '0;
            state   <= (cmd_count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (out_mem_rd_en) begin
            cur_idx <= cur_idx + 1'b1;
            issued  <= issued + 1'b1;
            if (last_rd) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tracks the single outstanding read so its data is pushed exactly one cycle after rd_en.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= out_mem_rd_en;
      inflight_last <= out_mem_rd_en & last_rd;
    end
  end

  out_store_fifo #(
    .W     (OUT_MEM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (OCC_W)
  ) u_fifo (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .push     (inflight),
    .push_dat ({inflight_last, out_mem_rd_data}),
    .pop      (pop),
    .head_dat (head),
    .cnt      (fifo_cnt)
  );
endmodule

// File: tb/tb_out_store.sv
// Purpose: directed bench for out_store with a one-cycle-latency row memory model.
// Latency: checks rd_en at cycle 1, first beat at cycle 3 and done at N+3 with m_ready held high.
// Backpressure: drives m_ready high or toggling and checks hold stability and read throttling.

module tb_out_store;
  logic         ap_clk = 1'b0;
  logic         ap_rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [11:0]  cmd_base_idx;
  logic [15:0]  cmd_count;
  logic         out_mem_rd_en;
  logic [31:0]  out_mem_rd_addr;
  logic [127:0] out_mem_rd_data;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         m_last;
  logic         busy;
  logic         done;

  int n_tot = 0;
  int n_bad = 0;

  out_store dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_base_idx    (cmd_base_idx),
    .cmd_count       (cmd_count),
    .out_mem_rd_en   (out_mem_rd_en),
    .out_mem_rd_addr (out_mem_rd_addr),
    .out_mem_rd_data (out_mem_rd_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_last          (m_last),
    .busy            (busy),
    .done            (done)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [127:0] row(input logic [11:0] r);
    logic [31:0] v;
    v = {20'b0, r} * 32'h11;
    return {4{v}};
  endfunction

  // Output-buffer model: data valid exactly one cycle after rd_en, junk otherwise.
  always @(posedge ap_clk)
    out_mem_rd_data <= out_mem_rd_en ? row(out_mem_rd_addr[13:2]) : {4{32'hDEADBEEF}};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Issues one command in the current cycle and follows it to done with a scoreboard.
  task automatic run_cmd(input logic [11:0] base, input logic [15:0] count, input bit toggle,
                         input bit keep, input logic [11:0] nbase, input logic [15:0] ncount);
    int cyc, n_rd, n_beat, n_last, outst, done_cyc, last_cyc;
    bit stalled, bad_rdy, got_done, pop;
    logic [127:0] hold_d;
    logic hold_l;
    logic [11:0] idx;
    cyc = 0; n_rd = 0; n_beat = 0; n_last = 0; outst = 0; done_cyc = -1; last_cyc = -1;
    stalled = 0; bad_rdy = 0; got_done = 0; hold_d = '0; hold_l = 0;
    cmd_valid = 1'b1; cmd_base_idx = base; cmd_count = count;
    m_ready = toggle ? 1'b0 : 1'b1;
    #1;
    check("hs_rdy", cmd_ready, 1);
    while (cyc < 300 && !got_done) begin
      step();
      cyc++;
      if (keep) begin
        cmd_base_idx = nbase; cmd_count = ncount;
      end else begin
        cmd_valid = 1'b0; cmd_base_idx = ~base; cmd_count = ~count;
      end
      m_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      #1;
      if (cmd_ready || !busy) bad_rdy = 1;
      pop = m_valid && m_ready;
      if (stalled) begin
        check("hold_vld", m_valid, 1);
        check("hold_dat", m_data, hold_d);
        check("hold_last", m_last, hold_l);
      end
      stalled = m_valid && !m_ready;
      if (stalled) begin
        hold_d = m_data; hold_l = m_last;
      end
      if (out_mem_rd_en) begin
        idx = base + 12'(n_rd);
        check("rd_addr", out_mem_rd_addr, {18'b0, idx, 2'b00});
        check("rd_room", (outst - int'(pop)) < 2, 1);
        check("rd_in_range", n_rd < int'(count), 1);
        if (!toggle) check("rd_cyc", cyc, n_rd + 1);
        n_rd++;
        outst++;
      end
      if (pop) begin
        check("beat_dat", m_data, row(base + 12'(n_beat)));
        check("beat_last", m_last, n_beat == int'(count) - 1);
        if (!toggle && n_beat == 0) check("first_beat_cyc", cyc, 3);
        if (m_last) begin
          n_last++; last_cyc = cyc;
        end
        n_beat++;
        outst--;
      end
      if (done) begin
        got_done = 1; done_cyc = cyc;
      end
    end
    check("done_seen", got_done, 1);
    check("beats", n_beat, count);
    check("reads", n_rd, count);
    check("lasts", n_last, (count == 0) ? 1'b0 : 1'b1);
    check("done_cyc", done_cyc, (count == 0) ? 1 : last_cyc + 1);
    if (!toggle && count != 0) check("done_lat", done_cyc, int'(count) + 3);
    check("rdy_low_busy", bad_rdy, 0);
    step();
    #1;
    check("rdy_back", cmd_ready, 1);
    check("done_clr", done, 0);
  endtask

  initial begin
    ap_rst = 1'b1; cmd_valid = 1'b0; cmd_base_idx = '0; cmd_count = '0; m_ready = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rd_en", out_mem_rd_en, 0);
    check("rst_rd_addr", out_mem_rd_addr, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    step();
    ap_rst = 1'b0;

    // Basic 4-row drain at full rate.
    run_cmd(12'd5, 16'd4, 1'b0, 1'b0, 12'd0, 16'd0);
    // Alternating backpressure.
    run_cmd(12'd9, 16'd3, 1'b1, 1'b0, 12'd0, 16'd0);
    // Row index wrap.
    run_cmd(12'hFFE, 16'd4, 1'b0, 1'b0, 12'd0, 16'd0);
    // Zero-length command.
    run_cmd(12'h123, 16'd0, 1'b0, 1'b0, 12'd0, 16'd0);
    // cmd_valid held across back-to-back commands.
    run_cmd(12'h010, 16'd2, 1'b0, 1'b1, 12'h020, 16'd1);
    run_cmd(12'h020, 16'd1, 1'b0, 1'b0, 12'd0, 16'd0);

    // Reset mid-stream with the FIFO full and the stream stalled.
    cmd_valid = 1'b1; cmd_base_idx = 12'h040; cmd_count = 16'd8; m_ready = 1'b0;
    #1;
    check("t5_hs", cmd_ready, 1);
    repeat (4) begin
      step();
      cmd_valid = 1'b0;
    end
    #1;
    check("t5_busy", busy, 1);
    check("t5_vld", m_valid, 1);
    ap_rst = 1'b1;
    #1;
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_rd_en", out_mem_rd_en, 0);
    check("t5_rd_addr", out_mem_rd_addr, 0);
    check("t5_m_valid", m_valid, 0);
    check("t5_m_last", m_last, 0);
    check("t5_m_data", m_data, 0);
    check("t5_busy_rst", busy, 0);
    check("t5_done", done, 0);
    step();
    ap_rst = 1'b0;
    run_cmd(12'd0, 16'd1, 1'b0, 1'b0, 12'd0, 16'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
